// File: rtl/fifo_stream_adapter_pkg.sv
// fifo_stream_adapter_pkg
//   Shared defaults, types and helpers for the FIFO read-side stream adapter.
//   Contents:
//     DEFAULT_FIFO_WIDTH / DEFAULT_SKID_DEPTH / DEFAULT_CNT_WIDTH : parameter defaults
//     fifo_word_t : one FIFO data word at the default width
//     occ_t       : skid occupancy count at the default depth
//     next_ptr()  : pointer increment that wraps at depth-1 (depth need not be 2^n)
package fifo_stream_adapter_pkg;

  localparam int DEFAULT_FIFO_WIDTH = 16;
  localparam int DEFAULT_SKID_DEPTH = 3;
  localparam int DEFAULT_CNT_WIDTH  = 16;
  localparam int DEFAULT_OCC_WIDTH  = $clog2(DEFAULT_SKID_DEPTH + 1);

  typedef logic [DEFAULT_FIFO_WIDTH-1:0] fifo_word_t;
  typedef logic [DEFAULT_OCC_WIDTH-1:0]  occ_t;

  function automatic int next_ptr(input int ptr, input int depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/fifo_stream_adapter_skid_ram.sv
// fifo_stream_adapter_skid_ram
//   DEPTH x WIDTH storage for the skid buffer: one synchronous write port and
//   one asynchronous read port. Pointer management lives in the parent.
//   Ports:
//     clk       : clock, rising edge
//     rst_n     : asynchronous active-low reset (clears all entries)
//     i_wr_en   : write strobe
//     i_wr_addr : write entry index
//     i_wr_data : write data
//     i_rd_addr : read entry index
//     o_rd_data : contents of entry i_rd_addr (combinational)
module fifo_stream_adapter_skid_ram
  import fifo_stream_adapter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_FIFO_WIDTH,
  parameter int DEPTH = DEFAULT_SKID_DEPTH,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [PTR_W-1:0] i_wr_addr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [PTR_W-1:0] i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0] w_wr_sel;

  // Per-entry write select decoded from the write address.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_sel
      assign w_wr_sel[gi] = i_wr_en && (i_wr_addr == PTR_W'(gi));
    end
  endgenerate

  // Entries are cleared on reset so m_data reads 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_wr_sel[i]) r_mem[i] <= i_wr_data;
      end
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/fifo_stream_adapter.sv
// fifo_stream_adapter
//   Read-side adapter for a synchronous FIFO whose data_out is valid the cycle
//   after a granted read. Issues fifo_rd_en against a credit check, captures
//   returning words into a small skid buffer and re-presents them as a
//   valid/ready stream. Counts delivered words.
//   Ports:
//     clk, rst_n    : clock (rising edge), asynchronous active-low reset
//     fifo_empty    : FIFO empty flag
//     fifo_data_out : FIFO read data (valid one cycle after fifo_rd_en)
//     fifo_rd_en    : read request to FIFO
//     flush         : synchronous discard of buffered and in-flight words
//     m_valid/m_data/m_ready : output stream
//     occupancy     : skid entries held
//     xfer_count    : words delivered, wraps
module fifo_stream_adapter
  import fifo_stream_adapter_pkg::*;
#(
  parameter int FIFO_WIDTH = DEFAULT_FIFO_WIDTH,
  parameter int SKID_DEPTH = DEFAULT_SKID_DEPTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             fifo_empty,
  input  logic [FIFO_WIDTH-1:0]            fifo_data_out,
  output logic                             fifo_rd_en,
  input  logic                             flush,
  output logic                             m_valid,
  output logic [FIFO_WIDTH-1:0]            m_data,
  input  logic                             m_ready,
  output logic [$clog2(SKID_DEPTH+1)-1:0]  occupancy,
  output logic [CNT_WIDTH-1:0]             xfer_count
);

  localparam int OCC_W = $clog2(SKID_DEPTH + 1);
  localparam int PTR_W = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
  localparam int LVL_W = OCC_W + 1;

  logic                  r_inflight;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [OCC_W-1:0]      r_occ;
  logic [CNT_WIDTH-1:0]  r_xfer;

  logic [LVL_W-1:0]      w_level;
  logic                  w_rd_en;
  logic                  w_valid;
  logic                  w_capture;
  logic                  w_pop;
  logic [FIFO_WIDTH-1:0] w_rd_data;

  // Credit check: held words plus the word already on its way from the FIFO
  // must leave room for one more. Only registered state feeds this, so there
  // is no path from m_ready. rst_n gating keeps the request low during reset.
  assign w_level   = LVL_W'(r_occ) + LVL_W'(r_inflight);
  assign w_rd_en   = rst_n && !fifo_empty && !flush && (w_level < LVL_W'(SKID_DEPTH));
  assign w_valid   = (r_occ != '0);
  // flush suppresses both capture of the in-flight word and any pop.
  assign w_capture = r_inflight && !flush;
  assign w_pop     = w_valid && m_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
      r_xfer     <= '0;
    end else if (flush) begin
      r_inflight <= 1'b0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_occ      <= '0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_capture) r_wr_ptr <= PTR_W'(next_ptr(int'(r_wr_ptr), SKID_DEPTH));
      if (w_pop) begin
        r_rd_ptr <= PTR_W'(next_ptr(int'(r_rd_ptr), SKID_DEPTH));
        r_xfer   <= r_xfer + 1'b1;
      end
      case ({w_capture, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  fifo_stream_adapter_skid_ram #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (SKID_DEPTH),
    .PTR_W (PTR_W)
  ) u_skid_ram (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_en   (w_capture),
    .i_wr_addr (r_wr_ptr),
    .i_wr_data (fifo_data_out),
    .i_rd_addr (r_rd_ptr),
    .o_rd_data (w_rd_data)
  );

  assign fifo_rd_en = w_rd_en;
  assign m_valid    = w_valid;
  assign m_data     = w_rd_data;
  assign occupancy  = r_occ;
  assign xfer_count = r_xfer;

endmodule

// File: tb/tb_fifo_stream_adapter.sv
// tb_fifo_stream_adapter
//   Directed bench: a behavioural FIFO (queue, data one cycle after read)
//   feeds the adapter; per-cycle expectation tables cover streaming and
//   back-pressure, hand-written sequences cover toggle, flush and reset.
module tb_fifo_stream_adapter;
  import fifo_stream_adapter_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       fifo_empty;
  fifo_word_t fifo_data_out;
  logic       fifo_rd_en;
  logic       flush;
  logic       m_valid;
  fifo_word_t m_data;
  logic       m_ready;
  occ_t       occupancy;
  logic [15:0] xfer_count;

  always #5 clk = ~clk;

  fifo_stream_adapter #(
    .FIFO_WIDTH (16),
    .SKID_DEPTH (3),
    .CNT_WIDTH  (16)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fifo_empty    (fifo_empty),
    .fifo_data_out (fifo_data_out),
    .fifo_rd_en    (fifo_rd_en),
    .flush         (flush),
    .m_valid       (m_valid),
    .m_data        (m_data),
    .m_ready       (m_ready),
    .occupancy     (occupancy),
    .xfer_count    (xfer_count)
  );

  fifo_word_t fifo_q[$];
  fifo_word_t out_q[$];
  int checks = 0;
  int errors = 0;
  int underflow_cnt = 0;
  int occ_max = 0;
  int total_beats = 0;

  typedef struct {
    logic       m_ready;
    logic       exp_rd_en;
    logic       exp_valid;
    fifo_word_t exp_data;
    occ_t       exp_occ;
    logic [15:0] exp_xfer;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rdy, input logic rd, input logic vld,
                              input int data, input int occ, input int xfer);
    vec_t v;
    v.m_ready   = rdy;
    v.exp_rd_en = rd;
    v.exp_valid = vld;
    v.exp_data  = fifo_word_t'(data);
    v.exp_occ   = occ_t'(occ);
    v.exp_xfer  = 16'(xfer);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // Called at posedge+2 (inputs settled): samples the read grant and the
  // stream handshake, then moves to posedge+1 and updates the FIFO model.
  task automatic advance();
    logic grant;
    grant = fifo_rd_en;
    if (grant && fifo_q.size() == 0) underflow_cnt++;
    if (int'(occupancy) > occ_max) occ_max = int'(occupancy);
    if (rst_n && m_valid && m_ready && !flush) begin
      out_q.push_back(m_data);
      total_beats++;
      $display("beat %0d data=0x%04h occupancy=%0d", total_beats, m_data, occupancy);
    end
    @(posedge clk);
    #1;
    if (grant && fifo_q.size() != 0) fifo_data_out = fifo_q.pop_front();
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic cyc();
    #1;
    advance();
  endtask

  task automatic preload(input int n);
    for (int k = 1; k <= n; k++) fifo_q.push_back(fifo_word_t'(k));
    fifo_empty = (fifo_q.size() == 0);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      m_ready = tbl[i].m_ready;
      flush   = 1'b0;
      #1;
      chk($sformatf("%s[%0d].rd_en", tag, i), 32'(fifo_rd_en), 32'(tbl[i].exp_rd_en));
      chk($sformatf("%s[%0d].valid", tag, i), 32'(m_valid), 32'(tbl[i].exp_valid));
      chk($sformatf("%s[%0d].occ", tag, i), 32'(occupancy), 32'(tbl[i].exp_occ));
      chk($sformatf("%s[%0d].xfer", tag, i), 32'(xfer_count), 32'(tbl[i].exp_xfer));
      if (tbl[i].exp_valid)
        chk($sformatf("%s[%0d].data", tag, i), 32'(m_data), 32'(tbl[i].exp_data));
      advance();
    end
  endtask

  task automatic drain(input string tag, input int n, input int budget);
    int b;
    b = budget;
    while (out_q.size() < n && b > 0) begin
      cyc();
      b--;
    end
    chk($sformatf("%s.count", tag), 32'(out_q.size()), 32'(n));
  endtask

  task automatic expect_seq(input string tag, input int first, input int n);
    for (int k = 0; k < n; k++) begin
      if (k < out_q.size())
        chk($sformatf("%s.word%0d", tag, k), 32'(out_q[k]), 32'(first + k));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    fifo_empty = 1'b1;
    fifo_data_out = '0;
    flush = 1'b0;
    m_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.rd_en", 32'(fifo_rd_en), 0);
    chk("reset.valid", 32'(m_valid), 0);
    chk("reset.data", 32'(m_data), 0);
    chk("reset.occ", 32'(occupancy), 0);
    chk("reset.xfer", 32'(xfer_count), 0);
    rst_n = 1'b1;

    // Idle with an empty FIFO.
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("idle[%0d].rd_en", i), 32'(fifo_rd_en), 0);
      chk($sformatf("idle[%0d].valid", i), 32'(m_valid), 0);
      chk($sformatf("idle[%0d].occ", i), 32'(occupancy), 0);
      chk($sformatf("idle[%0d].xfer", i), 32'(xfer_count), 0);
      advance();
    end

    // Full throughput: word w appears two cycles after its read, one per cycle.
    tbl.delete();
    tbl.push_back(mk(1, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1, 1, 0, 0, 0, 0));
    for (int c = 2; c <= 7; c++) tbl.push_back(mk(1, 1, 1, c - 1, 1, c - 2));
    tbl.push_back(mk(1, 0, 1, 7, 1, 6));
    tbl.push_back(mk(1, 0, 1, 8, 1, 7));
    tbl.push_back(mk(1, 0, 0, 0, 0, 8));
    preload(8);
    run_table("thru");

    // Back-pressure: three reads fill the buffer, head held, then release.
    tbl.delete();
    tbl.push_back(mk(0, 1, 0, 0, 0, 8));
    tbl.push_back(mk(0, 1, 0, 0, 0, 8));
    tbl.push_back(mk(0, 1, 1, 1, 1, 8));
    tbl.push_back(mk(0, 0, 1, 1, 2, 8));
    tbl.push_back(mk(0, 0, 1, 1, 3, 8));
    tbl.push_back(mk(0, 0, 1, 1, 3, 8));
    tbl.push_back(mk(1, 0, 1, 1, 3, 8));
    tbl.push_back(mk(1, 1, 1, 2, 2, 9));
    tbl.push_back(mk(1, 1, 1, 3, 1, 10));
    tbl.push_back(mk(1, 1, 1, 4, 1, 11));
    tbl.push_back(mk(1, 1, 1, 5, 1, 12));
    tbl.push_back(mk(1, 1, 1, 6, 1, 13));
    tbl.push_back(mk(1, 0, 1, 7, 1, 14));
    tbl.push_back(mk(1, 0, 1, 8, 1, 15));
    tbl.push_back(mk(1, 0, 0, 0, 0, 16));
    preload(8);
    run_table("bp");

    // m_ready toggling every cycle.
    out_q.delete();
    occ_max = 0;
    underflow_cnt = 0;
    preload(8);
    begin
      int c;
      c = 0;
      while (out_q.size() < 8 && c < 80) begin
        m_ready = (c % 2 == 0);
        cyc();
        c++;
      end
    end
    chk("toggle.count", 32'(out_q.size()), 8);
    expect_seq("toggle", 1, 8);
    m_ready = 1'b1;
    repeat (3) cyc();
    chk("toggle.occ_max_le_3", 32'(occ_max <= 3), 1);
    chk("toggle.underflow", 32'(underflow_cnt), 0);
    chk("toggle.xfer", 32'(xfer_count), 32'(16'(total_beats)));
    chk("toggle.xfer_abs", 32'(xfer_count), 24);

    // Flush with two words held and a third in flight.
    out_q.delete();
    m_ready = 1'b0;
    preload(8);
    cyc();
    cyc();
    #1;
    chk("flush.pre_occ", 32'(occupancy), 1);
    chk("flush.pre_rd_en", 32'(fifo_rd_en), 1);
    advance();
    flush = 1'b1;
    #1;
    chk("flush.occ_at_flush", 32'(occupancy), 2);
    chk("flush.rd_en_blocked", 32'(fifo_rd_en), 0);
    advance();
    flush = 1'b0;
    #1;
    chk("flush.occ_after", 32'(occupancy), 0);
    chk("flush.valid_after", 32'(m_valid), 0);
    chk("flush.xfer_after", 32'(xfer_count), 24);
    advance();
    m_ready = 1'b1;
    drain("flush_drain", 5, 40);
    expect_seq("flush_drain", 4, 5);
    repeat (3) cyc();
    chk("flush.xfer_end", 32'(xfer_count), 32'(16'(total_beats)));

    // Asynchronous reset mid-stream with two words held.
    out_q.delete();
    m_ready = 1'b0;
    preload(8);
    repeat (3) cyc();
    #1;
    chk("rst.pre_occ", 32'(occupancy), 2);
    rst_n = 1'b0;
    #1;
    chk("rst.rd_en", 32'(fifo_rd_en), 0);
    chk("rst.valid", 32'(m_valid), 0);
    chk("rst.data", 32'(m_data), 0);
    chk("rst.occ", 32'(occupancy), 0);
    chk("rst.xfer", 32'(xfer_count), 0);
    total_beats = 0;
    advance();
    #1;
    chk("rst.rd_en_held", 32'(fifo_rd_en), 0);
    advance();
    rst_n = 1'b1;
    m_ready = 1'b1;
    drain("rst_drain", 5, 40);
    expect_seq("rst_drain", 4, 5);
    repeat (3) cyc();
    chk("rst.xfer_end", 32'(xfer_count), 5);
    chk("final.underflow", 32'(underflow_cnt), 0);
    chk("final.occ_max_le_3", 32'(occ_max <= 3), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
